// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - SDRAM command encodings, controller states and address-field layout
package sdram_pkg;

    localparam int ROW_W    = 13;
    localparam int BANK_W   = 2;
    localparam int COL_W    = 10;
    localparam int COL_LSB  = 0;
    localparam int BANK_LSB = COL_LSB + COL_W;
    localparam int ROW_LSB  = BANK_LSB + BANK_W;
    localparam int ADDR_W   = ROW_LSB + ROW_W;

    // {RAS_N, CAS_N, WE_N}
    typedef enum logic [2:0] {
        CMD_NOP       = 3'b111,
        CMD_ACTIVE    = 3'b011,
        CMD_READ      = 3'b101,
        CMD_WRITE     = 3'b100,
        CMD_PRECHARGE = 3'b010,
        CMD_REFRESH   = 3'b001
    } cmd_t;

    typedef enum logic [1:0] {
        WAIT_INIT,
        IDLE,
        ACCESS,
        REFRESH
    } state_t;

    // Column address phase with A10 set so the bank auto-precharges after the burst
    function automatic logic [ROW_W-1:0] rw_addr(input logic [COL_W-1:0] col);
        return {2'b00, 1'b1, col};
    endfunction

endpackage

// File: rtl/sdram_refresh_timer.sv
// rtl/sdram_refresh_timer.sv - periodic refresh down-counter with sticky pending flag
module sdram_refresh_timer #(
    parameter int REF_INTERVAL = 780
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clear,
    output logic ref_pending
);

    localparam int CW = $clog2(REF_INTERVAL + 1);
    localparam logic [CW-1:0] RELOAD = CW'(REF_INTERVAL);

    logic [CW-1:0] cnt;
    logic          expire;

    assign expire = en && (cnt == '0);

    // A fresh expiry outranks a same-cycle clear; repeated expiries collapse into one flag
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt         <= RELOAD;
            ref_pending <= 1'b0;
        end else begin
            if (expire) begin
                cnt <= RELOAD;
            end else if (en) begin
                cnt <= cnt - 1'b1;
            end
            if (expire) begin
                ref_pending <= 1'b1;
            end else if (clear) begin
                ref_pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sdram_ctrl.sv
// rtl/sdram_ctrl.sv - run-time SDRAM sequencer (ACTIVE + auto-precharge R/W, refresh); option SDRAM_CTRL_STATS_EN
module sdram_ctrl #(
    parameter int TRCD         = 2,
    parameter int TRC          = 7,
    parameter int CAS          = 2,
    parameter int REF_INTERVAL = 780
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        init_done,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [24:0] req_addr,
    input  logic [15:0] req_wdata,
    input  logic [1:0]  req_wmask,
    output logic        rd_valid,
    output logic [15:0] rd_data,
    output logic        DRAM_CKE,
    output logic        DRAM_CS_N,
    output logic        DRAM_RAS_N,
    output logic        DRAM_CAS_N,
    output logic        DRAM_WE_N,
    output logic [12:0] DRAM_ADDR,
    output logic [1:0]  DRAM_BA,
    output logic        DRAM_LDQM,
    output logic        DRAM_UDQM,
    output logic [15:0] dq_out,
    output logic        dq_oe,
    input  logic [15:0] dq_in
`ifdef SDRAM_CTRL_STATS_EN
    ,
    output logic [31:0] stat_rd,
    output logic [31:0] stat_wr,
    output logic [31:0] stat_ref
`endif
);

    import sdram_pkg::*;

    localparam int TW = $clog2(TRC);
    localparam logic [TW-1:0] T_CMD  = TW'(TRCD);
    localparam logic [TW-1:0] T_CMD1 = TW'(TRCD + 1);
    localparam logic [TW-1:0] T_RD   = TW'(TRCD + CAS);
    localparam logic [TW-1:0] T_END  = TW'(TRC - 1);

    state_t            state, state_nx;
    logic [TW-1:0]     t, t_nx, t_inc;

    cmd_t              cmd_q, cmd_nx;
    logic [ROW_W-1:0]  addr_q, addr_nx;
    logic [BANK_W-1:0] ba_q, ba_nx;
    logic [1:0]        dqm_q, dqm_nx;
    logic [15:0]       dq_out_q, dq_out_nx;
    logic              dq_oe_q, dq_oe_nx;
    logic              rd_valid_q, rd_valid_nx;
    logic [15:0]       rd_data_q, rd_data_nx;

    logic              lat_we;
    logic [BANK_W-1:0] lat_bank;
    logic [COL_W-1:0]  lat_col;
    logic [15:0]       lat_wdata;
    logic [1:0]        lat_wmask;

    logic              accept;
    logic              ref_pending;
    logic              ref_clear;
    logic              ref_en;

    assign ref_en    = (state != WAIT_INIT);
    assign req_ready = (state == IDLE) && !ref_pending;

    sdram_refresh_timer #(
        .REF_INTERVAL(REF_INTERVAL)
    ) u_refresh_timer (
        .clk        (clk),
        .reset      (reset),
        .en         (ref_en),
        .clear      (ref_clear),
        .ref_pending(ref_pending)
    );

    // t counts the pin cycle currently on the bus; pins computed here belong to t+1
    always_comb begin
        state_nx    = state;
        t_nx        = t;
        t_inc       = t + 1'b1;
        cmd_nx      = CMD_NOP;
        addr_nx     = addr_q;
        ba_nx       = ba_q;
        dqm_nx      = 2'b11;
        dq_out_nx   = dq_out_q;
        dq_oe_nx    = 1'b0;
        rd_valid_nx = 1'b0;
        rd_data_nx  = rd_data_q;
        accept      = 1'b0;
        ref_clear   = 1'b0;
        case (state)
            WAIT_INIT: begin
                if (init_done) begin
                    state_nx = IDLE;
                end
            end
            IDLE: begin
                t_nx = '0;
                if (ref_pending) begin
                    cmd_nx    = CMD_REFRESH;
                    ref_clear = 1'b1;
                    state_nx  = REFRESH;
                end else if (req_valid) begin
                    accept   = 1'b1;
                    cmd_nx   = CMD_ACTIVE;
                    ba_nx    = req_addr[BANK_LSB +: BANK_W];
                    addr_nx  = req_addr[ROW_LSB +: ROW_W];
                    state_nx = ACCESS;
                end else if (!init_done) begin
                    // only drop back once no handshake can be in progress
                    state_nx = WAIT_INIT;
                end
            end
            ACCESS: begin
                t_nx = t_inc;
                if (t == T_END) begin
                    state_nx = IDLE;
                    t_nx     = '0;
                end else if (t_inc == T_CMD) begin
                    addr_nx = rw_addr(lat_col);
                    ba_nx   = lat_bank;
                    if (lat_we) begin
                        cmd_nx    = CMD_WRITE;
                        dqm_nx    = ~lat_wmask;
                        dq_oe_nx  = 1'b1;
                        dq_out_nx = lat_wdata;
                    end else begin
                        cmd_nx = CMD_READ;
                        dqm_nx = 2'b00;
                    end
                end else if (t_inc == T_CMD1 && !lat_we) begin
                    dqm_nx = 2'b00;
                end
                if (t == T_RD && !lat_we) begin
                    rd_valid_nx = 1'b1;
                    rd_data_nx  = dq_in;
                end
            end
            REFRESH: begin
                t_nx = t_inc;
                if (t == T_END) begin
                    state_nx = IDLE;
                    t_nx     = '0;
                end
            end
            default: begin
                state_nx = WAIT_INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= WAIT_INIT;
            t          <= '0;
            cmd_q      <= CMD_NOP;
            addr_q     <= '0;
            ba_q       <= '0;
            dqm_q      <= 2'b11;
            dq_out_q   <= '0;
            dq_oe_q    <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            lat_we     <= 1'b0;
            lat_bank   <= '0;
            lat_col    <= '0;
            lat_wdata  <= '0;
            lat_wmask  <= '0;
        end else begin
            state      <= state_nx;
            t          <= t_nx;
            cmd_q      <= cmd_nx;
            addr_q     <= addr_nx;
            ba_q       <= ba_nx;
            dqm_q      <= dqm_nx;
            dq_out_q   <= dq_out_nx;
            dq_oe_q    <= dq_oe_nx;
            rd_valid_q <= rd_valid_nx;
            rd_data_q  <= rd_data_nx;
            if (accept) begin
                lat_we    <= req_we;
                lat_bank  <= req_addr[BANK_LSB +: BANK_W];
                lat_col   <= req_addr[COL_LSB +: COL_W];
                lat_wdata <= req_wdata;
                lat_wmask <= req_wmask;
            end
        end
    end

`ifdef SDRAM_CTRL_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_rd  <= '0;
            stat_wr  <= '0;
            stat_ref <= '0;
        end else begin
            if (cmd_nx == CMD_READ)    stat_rd  <= stat_rd + 32'd1;
            if (cmd_nx == CMD_WRITE)   stat_wr  <= stat_wr + 32'd1;
            if (cmd_nx == CMD_REFRESH) stat_ref <= stat_ref + 32'd1;
        end
    end
`endif

    assign DRAM_CKE   = 1'b1;
    assign DRAM_CS_N  = 1'b0;
    assign DRAM_RAS_N = cmd_q[2];
    assign DRAM_CAS_N = cmd_q[1];
    assign DRAM_WE_N  = cmd_q[0];
    assign DRAM_ADDR  = addr_q;
    assign DRAM_BA    = ba_q;
    assign DRAM_UDQM  = dqm_q[1];
    assign DRAM_LDQM  = dqm_q[0];
    assign dq_out     = dq_out_q;
    assign dq_oe      = dq_oe_q;
    assign rd_valid   = rd_valid_q;
    assign rd_data    = rd_data_q;

endmodule

// File: tb/tb_sdram_ctrl.sv
// tb/tb_sdram_ctrl.sv - directed self-checking bench for sdram_ctrl with a small SDRAM model
module tb_sdram_ctrl;

    localparam logic [2:0] C_NOP = 3'b111, C_ACT = 3'b011, C_RD = 3'b101;
    localparam logic [2:0] C_WR = 3'b100, C_REF = 3'b001;

    logic        clk = 1'b0;
    logic        reset, init_done, req_valid, req_we;
    logic        req_ready, rd_valid;
    logic [24:0] req_addr;
    logic [15:0] req_wdata, rd_data, dq_out;
    logic [15:0] dq_in = 16'h5A5A;
    logic [1:0]  req_wmask;
    logic        DRAM_CKE, DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N;
    logic        DRAM_LDQM, DRAM_UDQM, dq_oe;
    logic [12:0] DRAM_ADDR;
    logic [1:0]  DRAM_BA;
    logic [2:0]  cmd;
`ifdef SDRAM_CTRL_STATS_EN
    logic [31:0] stat_rd, stat_wr, stat_ref;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;
    assign cmd = {DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N};

    sdram_ctrl dut (
        .clk(clk), .reset(reset), .init_done(init_done),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .DRAM_CKE(DRAM_CKE), .DRAM_CS_N(DRAM_CS_N), .DRAM_RAS_N(DRAM_RAS_N),
        .DRAM_CAS_N(DRAM_CAS_N), .DRAM_WE_N(DRAM_WE_N), .DRAM_ADDR(DRAM_ADDR),
        .DRAM_BA(DRAM_BA), .DRAM_LDQM(DRAM_LDQM), .DRAM_UDQM(DRAM_UDQM),
        .dq_out(dq_out), .dq_oe(dq_oe), .dq_in(dq_in)
`ifdef SDRAM_CTRL_STATS_EN
        , .stat_rd(stat_rd), .stat_wr(stat_wr), .stat_ref(stat_ref)
`endif
    );

    // SDRAM model: open row per bank, BL2 with beat 2 ignored, CL2 read data held for one cycle
    logic [15:0] mem [logic [24:0]];
    logic [12:0] open_row [4];
    logic [24:0] key, raddr;
    logic [15:0] old;
    int          rcnt = 0;

    always @(posedge clk) begin
        #1;
        if (rcnt > 0) rcnt = rcnt - 1;
        dq_in = (rcnt == 1) ? (mem.exists(raddr) ? mem[raddr] : 16'h0000) : 16'h5A5A;
        key = {open_row[DRAM_BA], DRAM_BA, DRAM_ADDR[9:0]};
        if (cmd == C_ACT) open_row[DRAM_BA] = DRAM_ADDR;
        if (cmd == C_WR && dq_oe) begin
            old = mem.exists(key) ? mem[key] : 16'h0000;
            if (!DRAM_LDQM) old[7:0] = dq_out[7:0];
            if (!DRAM_UDQM) old[15:8] = dq_out[15:8];
            mem[key] = old;
        end
        if (cmd == C_RD) begin
            raddr = key;
            rcnt  = 3;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad, pulses, pulse_t, hs, act, ref_cyc, act_before, act_after;
        logic seen_ref, prev_ready, ready_at_ref;

        reset = 1'b1; init_done = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        req_addr = '0; req_wdata = '0; req_wmask = '0;
        repeat (3) tick;
        chk("rst_cmd", 32'(cmd), 32'(C_NOP));
        chk("rst_addr_ba", 32'({DRAM_BA, DRAM_ADDR}), 32'd0);
        chk("rst_dqm", 32'({DRAM_UDQM, DRAM_LDQM}), 32'd3);
        chk("rst_dq", 32'({dq_oe, dq_out}), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_rd", 32'({rd_valid, rd_data}), 32'd0);
        chk("rst_cke_cs", 32'({DRAM_CKE, DRAM_CS_N}), 32'd2);

        // Gated by init_done with a pending write request
        reset = 1'b0; req_valid = 1'b1; req_we = 1'b1;
        req_addr = 25'h0ABC123; req_wdata = 16'hBEEF; req_wmask = 2'b11;
        bad = 0;
        repeat (100) begin
            tick;
            if (req_ready !== 1'b0 || cmd !== C_NOP) bad++;
        end
        chk("wait_init_quiet", 32'(bad), 32'd0);
        init_done = 1'b1;
        tick;
        chk("idle_ready", 32'(req_ready), 32'd1);
        chk("idle_nop", 32'(cmd), 32'(C_NOP));
        tick;
        chk("wr_active", 32'({cmd, DRAM_BA, DRAM_ADDR}), 32'({C_ACT, 2'b00, 13'h0ABC}));
        chk("wr_t0_ready", 32'(req_ready), 32'd0);
        req_valid = 1'b0; req_addr = 25'h1FFFFFF; req_wdata = 16'h0000; req_wmask = 2'b00;
        tick;
        chk("wr_t1_nop", 32'(cmd), 32'(C_NOP));
        tick;
        chk("wr_cmd", 32'({cmd, DRAM_BA, DRAM_ADDR}), 32'({C_WR, 2'b00, 13'h0523}));
        chk("wr_dq", 32'({dq_oe, dq_out}), 32'({1'b1, 16'hBEEF}));
        chk("wr_dqm", 32'({DRAM_UDQM, DRAM_LDQM}), 32'd0);
        tick;
        chk("wr_t3", 32'({cmd, DRAM_UDQM, DRAM_LDQM, dq_oe}), 32'({C_NOP, 2'b11, 1'b0}));
        repeat (3) tick;
        chk("wr_t6_ready", 32'(req_ready), 32'd0);
        tick;
        chk("wr_t7_ready", 32'(req_ready), 32'd1);

        // Full-word read back
        req_valid = 1'b1; req_we = 1'b0; req_addr = 25'h0ABC123;
        tick;
        chk("rd_active", 32'({cmd, DRAM_BA, DRAM_ADDR}), 32'({C_ACT, 2'b00, 13'h0ABC}));
        req_valid = 1'b0; req_addr = 25'h0000000;
        pulses = 0; pulse_t = -1;
        for (int k = 1; k <= 7; k++) begin
            tick;
            if (rd_valid === 1'b1) begin pulses++; pulse_t = k; end
            if (k == 2) chk("rd_cmd", 32'({cmd, DRAM_BA, DRAM_ADDR, DRAM_UDQM, DRAM_LDQM, dq_oe}),
                            32'({C_RD, 2'b00, 13'h0523, 3'b000}));
            if (k == 3) chk("rd_t3_dqm", 32'({DRAM_UDQM, DRAM_LDQM}), 32'd0);
            if (k == 4) chk("rd_t4_dqm", 32'({DRAM_UDQM, DRAM_LDQM}), 32'd3);
            if (k == 5) chk("rd_data", 32'(rd_data), 32'h0000BEEF);
            if (k == 7) chk("rd_t7_ready", 32'(req_ready), 32'd1);
        end
        chk("rd_pulses", 32'(pulses), 32'd1);
        chk("rd_pulse_t", 32'(pulse_t), 32'd5);

        // Lower-byte-only write, then read back the merged word
        req_valid = 1'b1; req_we = 1'b1; req_wdata = 16'h1234; req_wmask = 2'b01;
        req_addr = 25'h0ABC123;
        tick;
        req_valid = 1'b0;
        repeat (2) tick;
        chk("pw_dqm", 32'({DRAM_UDQM, DRAM_LDQM}), 32'd2);
        chk("pw_dq", 32'({dq_oe, dq_out}), 32'({1'b1, 16'h1234}));
        repeat (5) tick;
        req_valid = 1'b1; req_we = 1'b0;
        tick;
        req_valid = 1'b0;
        repeat (5) tick;
        chk("pw_readback", 32'({rd_valid, rd_data}), 32'({1'b1, 16'hBE34}));
        repeat (2) tick;

        // Back-to-back requests across a refresh expiry
        req_valid = 1'b1; req_we = 1'b0; req_addr = 25'h0ABC123;
        hs = 0; act = 0; ref_cyc = 0; act_before = 0; act_after = 0;
        seen_ref = 1'b0; ready_at_ref = 1'b1;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (req_valid && req_ready) hs++;
            prev_ready = req_ready;
            tick;
            if (cmd == C_REF && !seen_ref) begin
                seen_ref = 1'b1; ref_cyc = cyc; ready_at_ref = prev_ready;
            end
            if (cmd == C_ACT) begin
                act++;
                if (seen_ref) begin act_after = cyc; break; end
                act_before = cyc;
            end
        end
        req_valid = 1'b0;
        chk("ref_seen", 32'(seen_ref), 32'd1);
        chk("ref_ready_low", 32'(ready_at_ref), 32'd0);
        chk("ref_gap_after", 32'((act_after - ref_cyc) >= 7), 32'd1);
        chk("ref_gap_before", 32'((ref_cyc - act_before) >= 7), 32'd1);
        chk("no_req_lost", 32'(hs), 32'(act));

        // Reset during t3 of that read
        repeat (3) tick;
        chk("mid_t3_dqm", 32'({DRAM_UDQM, DRAM_LDQM}), 32'd0);
        reset = 1'b1; init_done = 1'b0;
        tick;
        chk("mid_rst_pins", 32'({cmd, DRAM_UDQM, DRAM_LDQM, dq_oe, rd_valid}),
            32'({C_NOP, 2'b11, 1'b0, 1'b0}));
        reset = 1'b0; req_valid = 1'b1;
        pulses = 0; bad = 0;
        repeat (10) begin
            tick;
            if (rd_valid === 1'b1) pulses++;
            if (req_ready !== 1'b0 || cmd !== C_NOP) bad++;
        end
        chk("mid_no_rd_valid", 32'(pulses), 32'd0);
        chk("mid_wait_init", 32'(bad), 32'd0);
        init_done = 1'b1;
        repeat (2) tick;
        chk("regate_active", 32'(cmd), 32'(C_ACT));
        req_valid = 1'b0;

        // init_done falling in IDLE returns to WAIT_INIT
        repeat (7) tick;
        chk("fall_idle_ready", 32'(req_ready), 32'd1);
        init_done = 1'b0;
        tick;
        req_valid = 1'b1;
        bad = 0;
        repeat (5) begin
            tick;
            if (req_ready !== 1'b0 || cmd !== C_NOP) bad++;
        end
        chk("fall_wait_init", 32'(bad), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
